// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// start is sampled only while busy=0; done pulses for one cycle with bcd_out/ovf new and stable until the next done.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 (double dabble) converter, one binary bit per clock.
// Feeds packed BCD digits to the downstream single-digit BCD adder.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    bin_to_bcd_seq_if.slave       bus,
    output logic                  dbg_state
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [BIN_W-1:0] sh_q;
    logic [DW-1:0]   dig_q;
    logic [CW-1:0]   cnt_q;
    logic            acc_q;
    logic [DW-1:0]   bcd_q;
    logic            ovf_q;
    logic            done_q;

    logic [DW-1:0]   adj;
    logic [DW-1:0]   dig_next;
    logic [BIN_W-1:0] sh_next;
    logic            shout;
    logic            last_step;

    // Digits are adjusted independently; a 4-bit wrap can't happen since only 5..9 get +3.
    always_comb begin
        adj = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
        end
        shout    = adj[DW-1];
        dig_next = {adj[DW-2:0], sh_q[BIN_W-1]};
        sh_next  = {sh_q[BIN_W-2:0], 1'b0};
        last_step = (cnt_q == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CONV;
            CONV:    if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q == CONV);
        bus.done    = done_q;
        bus.bcd_out = bcd_q;
        bus.ovf     = ovf_q;
        dbg_state   = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            dig_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= 1'b0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    sh_q  <= bus.bin_in;
                    dig_q <= '0;
                    cnt_q <= CW'(BIN_W);
                    acc_q <= 1'b0;
                end
            end else begin
                sh_q  <= sh_next;
                dig_q <= dig_next;
                cnt_q <= cnt_q - CW'(1);
                acc_q <= acc_q | shout;
                if (last_step) begin
                    bcd_q  <= dig_next;
                    ovf_q  <= acc_q | shout;
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit instance and a 2-digit overflow instance.
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst;
  logic dbg3, dbg2;
  int   n_vec = 0;
  int   n_err = 0;

  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) ifc ();
  bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) ifc2 ();

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .dbg_state(dbg3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(ifc2.slave), .dbg_state(dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] dec3(input int v);
    dec3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    ifc.start = 1'b0;  ifc.bin_in = '0;
    ifc2.start = 1'b0; ifc2.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.bcd_out !== 12'h000 ||
        ifc.ovf !== 1'b0 || dbg3 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h ovf=%b st=%b required 0 0 000 0 0",
               ifc.busy, ifc.done, ifc.bcd_out, ifc.ovf, dbg3);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp_bcd, input string name);
    @(negedge clk);
    ifc.start = 1'b1; ifc.bin_in = v;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      n_vec++;
      if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
        n_err++;
        $display("FAIL %s_cycle%0d: busy=%b done=%b required busy=1 done=0",
                 name, c, ifc.busy, ifc.done);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (ifc.done !== 1'b1 || ifc.busy !== 1'b0 || ifc.bcd_out !== exp_bcd || ifc.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL %s_result: done=%b busy=%b bcd=%h ovf=%b required 1 0 %h 0",
               name, ifc.done, ifc.busy, ifc.bcd_out, ifc.ovf, exp_bcd);
    end
    @(posedge clk); #1;
    n_vec++;
    if (ifc.done !== 1'b0 || ifc.bcd_out !== exp_bcd) begin
      n_err++;
      $display("FAIL %s_hold: done=%b bcd=%h required 0 %h", name, ifc.done, ifc.bcd_out, exp_bcd);
    end
  endtask

  task automatic test_basic;
    run_conv(8'd0,   12'h000, "zero");
    run_conv(8'd255, 12'h255, "max");
    run_conv(8'd99,  12'h099, "v99");
    run_conv(8'd100, 12'h100, "v100");
  endtask

  task automatic test_back_to_back;
    int dones;
    dones = 0;
    @(negedge clk);
    ifc.start = 1'b1; ifc.bin_in = 8'd0;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    for (int v = 0; v < 256; v++) begin
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        if (ifc.done === 1'b1) dones++;
        if (c < 8 && ifc.done !== 1'b0) begin
          n_vec++; n_err++;
          $display("FAIL b2b_early_done: v=%0d cycle=%0d done=%b required 0", v, c, ifc.done);
        end
      end
      n_vec++;
      if (ifc.done !== 1'b1 || ifc.bcd_out !== dec3(v) || ifc.ovf !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_v%0d: done=%b bcd=%h ovf=%b required 1 %h 0",
                 v, ifc.done, ifc.bcd_out, ifc.ovf, dec3(v));
      end
      // relaunch inside the done cycle
      ifc.start  = (v < 255);
      ifc.bin_in = 8'(v + 1);
      if (v < 255) begin
        @(posedge clk); #1;
        ifc.start = 1'b0;
        n_vec++;
        if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_relaunch_v%0d: busy=%b done=%b required 1 0", v, ifc.busy, ifc.done);
        end
      end
    end
    n_vec++;
    if (dones != 256) begin
      n_err++;
      $display("FAIL b2b_done_count: got %0d required 256", dones);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy;
    int dones;
    dones = 0;
    @(negedge clk);
    ifc.start = 1'b1; ifc.bin_in = 8'd7;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin ifc.start = 1'b1; ifc.bin_in = 8'd200; end
      if (c == 3) ifc.start = 1'b0;
      if (ifc.done === 1'b1) dones++;
      if (c < 8) begin
        n_vec++;
        if (ifc.busy !== 1'b1) begin
          n_err++;
          $display("FAIL busy_hold_cycle%0d: busy=%b required 1", c, ifc.busy);
        end
      end
    end
    n_vec++;
    if (ifc.done !== 1'b1 || ifc.bcd_out !== 12'h007) begin
      n_err++;
      $display("FAIL ignore_start_result: done=%b bcd=%h required 1 007", ifc.done, ifc.bcd_out);
    end
    repeat (10) begin
      @(posedge clk); #1;
      if (ifc.done === 1'b1) dones++;
    end
    n_vec++;
    if (dones != 1 || ifc.busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_start_single_done: dones=%0d busy=%b required 1 0", dones, ifc.busy);
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    ifc.start = 1'b1; ifc.bin_in = 8'd123;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.bcd_out !== 12'h000 || dbg3 !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async: busy=%b done=%b bcd=%h st=%b required 0 0 000 0",
               ifc.busy, ifc.done, ifc.bcd_out, dbg3);
    end
    @(negedge clk);
    rst = 1'b0;
    run_conv(8'd45, 12'h045, "after_abort");
  endtask

  task automatic run_conv2(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf,
                           input string name);
    @(negedge clk);
    ifc2.start = 1'b1; ifc2.bin_in = v;
    @(posedge clk); #1;
    ifc2.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (ifc2.done !== 1'b1 || ifc2.bcd_out !== exp_bcd || ifc2.ovf !== exp_ovf) begin
      n_err++;
      $display("FAIL %s: done=%b bcd=%h ovf=%b required 1 %h %b",
               name, ifc2.done, ifc2.bcd_out, ifc2.ovf, exp_bcd, exp_ovf);
    end
  endtask

  task automatic test_overflow;
    run_conv2(8'd200, 8'h00, 1'b1, "d2_v200_ovf");
    run_conv2(8'd99,  8'h99, 1'b0, "d2_v99");
    run_conv2(8'd150, 8'h50, 1'b1, "d2_v150_ovf");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_while_busy();
    test_abort();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm.
- Sits directly upstream of the single-digit BCD adder stage. It turns binary counts and operands into packed BCD digits, which are then fed one nibble at a time into the BCD adder.
- One bit is processed per clock. A start/done handshake frames each conversion.

Parameters:
- BIN_W, 8, width of the binary input; equals the number of conversion cycles.
- DIGITS, 3, number of BCD output digits; bcd_out is 4*DIGITS bits wide.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request a conversion; sampled only while idle.
- bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and ovf are valid and new.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 is in bits [3:0], the most significant digit is in the top nibble.
- ovf  output  1  high if the value exceeded 10^DIGITS-1; bcd_out then holds the low digits only.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, bcd_out=0, ovf=0.
  - Shift register, digit register and counter are cleared.
  - A reset mid-conversion aborts it with no done pulse.
  - First start is accepted on the first rising edge after rst deasserts.
- States: IDLE, CONV.
- IDLE:
  - done is driven 0 on any edge that does not complete a conversion.
  - If start=1 at edge E0: capture bin_in into the shift register, clear the working digits, set cnt=BIN_W, clear the overflow accumulator, set busy=1, go to CONV.
  - If start=0: hold state; bcd_out and ovf keep the last result.
- CONV, one step per edge E1..E_BIN_W:
  - First, every working digit >=5 gets +3 (4-bit result, no carry between digits).
  - Then shift the whole {digits, shift register} left by 1. The MSB of the shift register enters digit 0 bit 0.
  - The bit shifted out of the top digit is ORed into the overflow accumulator.
  - cnt decrements each step.
- Completion, at the edge where cnt goes 1->0 (edge E_BIN_W):
  - bcd_out <= adjusted-and-shifted digits; ovf <= accumulator (including this step's shift-out).
  - done <= 1 for exactly one cycle; busy <= 0; state -> IDLE.
- Latency: done is seen high in the cycle after edge E_BIN_W, i.e. BIN_W cycles after the accepting edge. Throughput is one conversion per BIN_W cycles.
- start while busy: ignored, not queued; bin_in changes during CONV have no effect.
- start high in the done cycle: accepted (state is IDLE), giving back-to-back conversions. done falls and busy rises on the same edge.
- bcd_out and ovf change only on completion edges (or reset); they are stable otherwise.
- Every output digit is always in the range 0..9.
- With BIN_W=8, DIGITS=3 overflow is impossible (max 255).

Test Plan:
- BIN_W=8, DIGITS=3. Reset, then start with bin_in=0 -> after 8 cycles done=1 for 1 cycle, bcd_out=12'h000, ovf=0, busy=0.
- bin_in=255 -> bcd_out=12'h255. bin_in=99 -> 12'h099. bin_in=100 -> 12'h100. Each done exactly 8 cycles after the start edge.
- Exhaustive 0..255, with start asserted on each done cycle (back-to-back): every bcd_out matches the decimal reference, one conversion per 8 cycles, no lost or duplicated done pulses.
- start=1 with bin_in=7 accepted; pulse start again with bin_in=200 at cycle 3 of the conversion -> result 12'h007, only one done pulse, busy stays high through the conversion.
- Assert rst at cycle 4 of a conversion of 123 -> busy=0, done=0, bcd_out=0 immediately (async). Next start with 45 -> 12'h045.
- BIN_W=8, DIGITS=2. bin_in=200 -> bcd_out=8'h00, ovf=1. bin_in=99 -> 8'h99, ovf=0.
